// File: rtl/fpu_wb_buffer_if.sv
// Handshake bundle between the FPU result port, the FP register-file writeback
// port and the fflags CSR. The buffer connects through the slave modport.
interface fpu_wb_buffer_if #(
    parameter int unsigned FLEN = 32
);
    logic            i_in_valid;
    logic            o_in_ready;
    logic [FLEN-1:0] i_result;
    logic [4:0]      i_fflags;
    logic [4:0]      i_rd;
    logic            o_wb_valid;
    logic            i_wb_ready;
    logic [FLEN-1:0] o_wb_result;
    logic [4:0]      o_wb_rd;
    logic            i_csr_we;
    logic [4:0]      i_csr_wdata;
    logic [4:0]      o_fflags_csr;

    modport slave (
        input  i_in_valid, i_result, i_fflags, i_rd, i_wb_ready, i_csr_we, i_csr_wdata,
        output o_in_ready, o_wb_valid, o_wb_result, o_wb_rd, o_fflags_csr
    );

    modport master (
        output i_in_valid, i_result, i_fflags, i_rd, i_wb_ready, i_csr_we, i_csr_wdata,
        input  o_in_ready, o_wb_valid, o_wb_result, o_wb_rd, o_fflags_csr
    );
endinterface

// File: rtl/fpu_wb_buffer.sv
// FPU writeback FIFO with sticky fflags accumulation on retirement.
// Define FPU_WB_BYPASS_EN for a zero-latency path when the buffer is empty.
module fpu_wb_buffer #(
    parameter int unsigned FLEN  = 32,
    parameter int unsigned DEPTH = 2
) (
    input logic           i_clk,
    input logic           i_rst,
    fpu_wb_buffer_if.slave bus
);
    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [FLEN-1:0] mem_result [DEPTH];
    logic [4:0]      mem_rd     [DEPTH];
    logic [4:0]      mem_flags  [DEPTH];

    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic          ready_en;
    logic [4:0]    fflags_q;

    logic          full;
    logic          empty;
    logic          push_hs;
    logic          pop_q;
    logic          bypass_fire;
    logic          store;
    logic          retire;
    logic [4:0]    head_flags;

    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);

    // Ready depends only on registered state; held low until the cycle after reset.
    assign bus.o_in_ready   = ready_en & ~full;
    assign bus.o_fflags_csr = fflags_q;

    assign push_hs = bus.i_in_valid & bus.o_in_ready;
    assign pop_q   = ~empty & bus.i_wb_ready;

`ifdef FPU_WB_BYPASS_EN
    logic bypass;
    assign bypass      = empty & push_hs;
    assign bypass_fire = bypass & bus.i_wb_ready;

    always_comb begin
        bus.o_wb_valid  = 1'b0;
        bus.o_wb_result = '0;
        bus.o_wb_rd     = '0;
        if (!empty) begin
            bus.o_wb_valid  = 1'b1;
            bus.o_wb_result = mem_result[rd_ptr];
            bus.o_wb_rd     = mem_rd[rd_ptr];
        end else if (bypass) begin
            bus.o_wb_valid  = 1'b1;
            bus.o_wb_result = bus.i_result;
            bus.o_wb_rd     = bus.i_rd;
        end
    end
`else
    assign bypass_fire = 1'b0;

    // Head is masked while empty so outputs read zero after reset without clearing storage.
    always_comb begin
        bus.o_wb_valid  = 1'b0;
        bus.o_wb_result = '0;
        bus.o_wb_rd     = '0;
        if (!empty) begin
            bus.o_wb_valid  = 1'b1;
            bus.o_wb_result = mem_result[rd_ptr];
            bus.o_wb_rd     = mem_rd[rd_ptr];
        end
    end
`endif

    assign store      = push_hs & ~bypass_fire;
    assign retire     = pop_q | bypass_fire;
    assign head_flags = bypass_fire ? bus.i_fflags : mem_flags[rd_ptr];

    always_ff @(posedge i_clk) begin
        if (store) begin
            mem_result[wr_ptr] <= bus.i_result;
            mem_rd[wr_ptr]     <= bus.i_rd;
            mem_flags[wr_ptr]  <= bus.i_fflags;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            ready_en <= 1'b0;
            fflags_q <= '0;
        end else begin
            ready_en <= 1'b1;
            if (store) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop_q) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            count <= count + CW'(store) - CW'(pop_q);
            // A CSR write still keeps flags retiring in the same cycle.
            fflags_q <= (bus.i_csr_we ? bus.i_csr_wdata : fflags_q)
                        | (retire ? head_flags : 5'd0);
        end
    end
endmodule

// File: tb/tb_fpu_wb_buffer.sv
// Directed and randomized checks of fpu_wb_buffer against a queue-based model.
module tb_fpu_wb_buffer;
    localparam int unsigned FLEN  = 32;
    localparam int unsigned DEPTH = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    fpu_wb_buffer_if #(.FLEN(FLEN)) bus ();

    fpu_wb_buffer #(.FLEN(FLEN), .DEPTH(DEPTH)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    int vectors = 0;
    int miscompares = 0;

    typedef struct {
        logic [31:0] res;
        logic [4:0]  rd;
        logic [4:0]  fl;
    } ent_t;

    ent_t        q[$];
    logic [4:0]  csr_model;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_in(input logic v, input logic [31:0] res, input logic [4:0] rd,
                            input logic [4:0] fl);
        bus.i_in_valid = v;
        bus.i_result   = res;
        bus.i_rd       = rd;
        bus.i_fflags   = fl;
    endtask

    initial begin
        drive_in(1'b0, '0, '0, '0);
        bus.i_wb_ready  = 1'b0;
        bus.i_csr_we    = 1'b0;
        bus.i_csr_wdata = '0;

        // Reset state
        rst = 1'b1;
        tick();
        tick();
        chk("rst_wb_valid", 64'(bus.o_wb_valid), 0);
        chk("rst_in_ready", 64'(bus.o_in_ready), 0);
        chk("rst_csr", 64'(bus.o_fflags_csr), 0);
        chk("rst_wb_result", 64'(bus.o_wb_result), 0);
        chk("rst_wb_rd", 64'(bus.o_wb_rd), 0);
        rst = 1'b0;
        tick();
        chk("post_rst_ready", 64'(bus.o_in_ready), 1);

        // Single op, one cycle latency
        bus.i_wb_ready = 1'b1;
        drive_in(1'b1, 32'h4060_0000, 5'd3, 5'h00);
        #1;
        chk("single_no_bypass", 64'(bus.o_wb_valid), 0);
        tick();
        drive_in(1'b0, '0, '0, '0);
        chk("single_valid", 64'(bus.o_wb_valid), 1);
        chk("single_rd", 64'(bus.o_wb_rd), 3);
        chk("single_result", 64'(bus.o_wb_result), 64'h4060_0000);
        tick();
        chk("single_drained", 64'(bus.o_wb_valid), 0);
        chk("single_csr", 64'(bus.o_fflags_csr), 0);

        // Backpressure and full-with-simultaneous-pop
        bus.i_wb_ready = 1'b0;
        drive_in(1'b1, 32'hA, 5'd1, 5'h00);
        tick();
        drive_in(1'b1, 32'hB, 5'd2, 5'h00);
        tick();
        chk("bp_full_ready", 64'(bus.o_in_ready), 0);
        chk("bp_head_a", 64'(bus.o_wb_result), 64'hA);
        drive_in(1'b1, 32'hC, 5'd7, 5'h00);
        tick();
        chk("bp_third_wait", 64'(bus.o_in_ready), 0);
        chk("bp_head_still_a", 64'(bus.o_wb_rd), 1);
        bus.i_wb_ready = 1'b1;
        tick();
        chk("full_pop_no_push_ready", 64'(bus.o_in_ready), 1);
        chk("full_pop_head_b", 64'(bus.o_wb_result), 64'hB);
        bus.i_wb_ready = 1'b0;
        tick();
        chk("next_cycle_push_full", 64'(bus.o_in_ready), 0);
        chk("next_cycle_head_b", 64'(bus.o_wb_rd), 2);
        drive_in(1'b0, '0, '0, '0);
        bus.i_wb_ready = 1'b1;
        tick();
        chk("order_c_result", 64'(bus.o_wb_result), 64'hC);
        chk("order_c_rd", 64'(bus.o_wb_rd), 7);
        tick();
        chk("bp_empty", 64'(bus.o_wb_valid), 0);

        // Flag accumulation on pop only
        bus.i_wb_ready = 1'b0;
        drive_in(1'b1, 32'h1, 5'd4, 5'h01);
        tick();
        drive_in(1'b1, 32'h2, 5'd5, 5'h05);
        tick();
        drive_in(1'b0, '0, '0, '0);
        chk("no_acc_on_push", 64'(bus.o_fflags_csr), 0);
        bus.i_wb_ready = 1'b1;
        tick();
        chk("acc_nx", 64'(bus.o_fflags_csr), 64'h01);
        tick();
        chk("acc_of_nx", 64'(bus.o_fflags_csr), 64'h05);
        drive_in(1'b1, 32'h3, 5'd6, 5'h08);
        tick();
        drive_in(1'b0, '0, '0, '0);
        tick();
        chk("acc_dz", 64'(bus.o_fflags_csr), 64'h0D);

        // CSR write colliding with a pop
        bus.i_wb_ready = 1'b0;
        drive_in(1'b1, 32'h4, 5'd8, 5'h10);
        tick();
        drive_in(1'b0, '0, '0, '0);
        bus.i_csr_we    = 1'b1;
        bus.i_csr_wdata = 5'h00;
        bus.i_wb_ready  = 1'b1;
        tick();
        chk("csr_collision", 64'(bus.o_fflags_csr), 64'h10);
        bus.i_wb_ready  = 1'b0;
        bus.i_csr_wdata = 5'h03;
        tick();
        bus.i_csr_we = 1'b0;
        chk("csr_write", 64'(bus.o_fflags_csr), 64'h03);
        csr_model = 5'h03;

        // Randomized traffic against the queue model
        for (int n = 0; n < 400; n++) begin
            logic iv, wr, we;
            logic push, pop;
            logic [4:0] retired;
            ent_t e;
            iv = 1'($urandom_range(0, 1));
            wr = 1'($urandom_range(0, 2) != 0);
            we = ($urandom_range(0, 15) == 0);
            e.res = $urandom;
            e.rd  = 5'($urandom);
            e.fl  = 5'($urandom);
            drive_in(iv, e.res, e.rd, e.fl);
            bus.i_wb_ready  = wr;
            bus.i_csr_we    = we;
            bus.i_csr_wdata = 5'($urandom);
            #1;
            chk("rnd_valid", 64'(bus.o_wb_valid), 64'(q.size() != 0));
            chk("rnd_ready", 64'(bus.o_in_ready), 64'(q.size() < DEPTH));
            chk("rnd_csr", 64'(bus.o_fflags_csr), 64'(csr_model));
            if (q.size() != 0) begin
                chk("rnd_result", 64'(bus.o_wb_result), 64'(q[0].res));
                chk("rnd_rd", 64'(bus.o_wb_rd), 64'(q[0].rd));
            end
            push    = iv && (q.size() < DEPTH);
            pop     = wr && (q.size() != 0);
            retired = pop ? q[0].fl : 5'h00;
            csr_model = (we ? bus.i_csr_wdata : csr_model) | retired;
            if (pop) void'(q.pop_front());
            if (push) q.push_back(e);
            tick();
        end
        drive_in(1'b0, '0, '0, '0);
        bus.i_csr_we = 1'b0;
        chk("rnd_final_csr", 64'(bus.o_fflags_csr), 64'(csr_model));

        // Reset mid-stream discards held entries
        bus.i_wb_ready = 1'b0;
        tick();
        tick();
        drive_in(1'b1, 32'h55, 5'd9, 5'h1F);
        tick();
        tick();
        drive_in(1'b0, '0, '0, '0);
        chk("mid_full", 64'(bus.o_in_ready), 0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        bus.i_wb_ready = 1'b1;
        chk("mid_rst_valid", 64'(bus.o_wb_valid), 0);
        chk("mid_rst_csr", 64'(bus.o_fflags_csr), 0);
        tick();
        chk("mid_rst_ready", 64'(bus.o_in_ready), 1);
        chk("mid_rst_no_wb", 64'(bus.o_wb_valid), 0);
        chk("mid_rst_csr_held", 64'(bus.o_fflags_csr), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/fpu_wb_buffer.md
FPU_WB_BUFFER -- requirements
Module: fpu_wb_buffer

Interface
REQ-001 Parameter FLEN, default 32: result data width.
REQ-002 Parameter DEPTH, default 2: FIFO entries; SHALL be a power of two, at least 2.
REQ-003 i_clk  input  1  sole clock; all state updates on rising edge.
REQ-004 i_rst  input  1  synchronous, active-high reset.
REQ-005 i_in_valid  input  1  FPU result valid; connects to FPU o_out_valid.
REQ-006 o_in_ready  output  1  buffer can accept; connects to FPU i_out_ready.
REQ-007 i_result  input  FLEN  FPU result; connects to FPU o_result.
REQ-008 i_fflags  input  5  FPU exception flags {NV,DZ,OF,UF,NX}; connects to FPU o_fflags.
REQ-009 i_rd  input  5  destination FP register index of the accepted op.
REQ-010 o_wb_valid  output  1  writeback entry present.
REQ-011 i_wb_ready  input  1  register file accepts writeback.
REQ-012 o_wb_result  output  FLEN  head-entry result.
REQ-013 o_wb_rd  output  5  head-entry destination index.
REQ-014 i_csr_we  input  1  software write to fflags.
REQ-015 i_csr_wdata  input  5  fflags write value.
REQ-016 o_fflags_csr  output  5  sticky accumulated fflags.

Function
REQ-017 Push SHALL occur when i_in_valid & o_in_ready. Pop SHALL occur when o_wb_valid & i_wb_ready.
REQ-018 o_in_ready SHALL equal !full, registered-state only, with no combinational path from i_wb_ready.
REQ-019 When full, a push SHALL be blocked even if a pop occurs in the same cycle; the slot frees on the next cycle.
REQ-020 When neither empty nor full, simultaneous push and pop SHALL leave the count unchanged and keep FIFO order.
REQ-021 The count SHALL range 0..DEPTH. Read and write pointers SHALL wrap modulo DEPTH.
REQ-022 o_wb_valid SHALL equal !empty (bypass excluded, see REQ-029). o_wb_result and o_wb_rd SHALL present the head entry.
REQ-023 Without bypass, the latency from push to o_wb_valid SHALL be exactly 1 cycle.
REQ-024 On pop, o_fflags_csr SHALL be updated to o_fflags_csr | head.fflags on the next edge.
REQ-025 On i_csr_we without a pop, o_fflags_csr SHALL become i_csr_wdata.
REQ-026 On i_csr_we in the same cycle as a pop, o_fflags_csr SHALL become i_csr_wdata | head.fflags, so no popped flag is lost.
REQ-027 Flags SHALL accumulate only on pop, never on push.

Reset
REQ-028 While i_rst=1 at an edge, the following SHALL be cleared: count, pointers, o_fflags_csr=0, o_wb_valid=0, o_wb_result=0, o_wb_rd=0, o_in_ready=0. o_in_ready SHALL rise the cycle after i_rst deasserts. Reset mid-operation SHALL discard all entries with no writeback.

Configuration
REQ-029 Macro FPU_WB_BYPASS_EN:
- Defined: when the buffer is empty and i_in_valid=1, the input SHALL drive o_wb_valid, o_wb_result and o_wb_rd combinationally.
- Defined: if i_wb_ready=1 in that cycle, the entry SHALL retire with zero latency, without being stored, and its flags SHALL accumulate as a pop.
- Defined: otherwise the entry SHALL be pushed normally.
- Undefined: there SHALL be no input-to-output combinational path, and REQ-023 applies.

Verification
REQ-030 Single op: push result 0x40600000, rd=3, flags=0, with i_wb_ready=1 -> o_wb_valid high 1 cycle later with rd=3 and result 0x40600000 (cycle 0 with FPU_WB_BYPASS_EN); o_fflags_csr=0.
REQ-031 Backpressure: i_wb_ready=0, push 3 ops -> o_in_ready low after DEPTH=2 accepted; 3rd waits; release -> results retire in order with no loss or duplication.
REQ-032 Flag accumulation: pop NX (0x01) then OF|NX (0x05) -> o_fflags_csr=0x05; pop DZ (0x08) -> 0x0D.
REQ-033 CSR collision: i_csr_we=1 with wdata 0x00 in the same cycle as a pop with flags 0x10 -> o_fflags_csr=0x10.
REQ-034 Full plus simultaneous pop: buffer full, i_in_valid=1, i_wb_ready=1 -> no push that cycle; push accepted next cycle; count stays 2.
REQ-035 Reset mid-stream: 2 entries held, i_rst=1 for 1 cycle -> o_wb_valid=0, o_fflags_csr=0, o_in_ready=1 on the next cycle.
